// File: rtl/lib_pkg.sv
// Shared definitions for the lib_ datapath blocks: handshake bundle and
// width helpers used by the pipeline register and its successors.
package lib_pkg;

  typedef struct packed {
    logic valid;
    logic ready;
  } handshake_t;

  // Occupancy must represent 0..depth inclusive, hence depth+1 states.
  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lib_pipe_stage.sv
// One pipeline stage: a valid flop plus a data flop that only loads when the
// upstream beat is valid, so idle-cycle garbage never enters the datapath.
module lib_pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Flush clears only the valid bit; the data register keeps its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/lib_pipe_reg.sv
// Multi-stage valid/ready pipeline register with bubble collapse, synchronous
// flush and an exported occupancy count.
module lib_pipe_reg
  import lib_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              OW        = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [OW-1:0]    occupancy
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d [DEPTH];
  logic             tail_full;
  handshake_t       in_hs;
  handshake_t       out_hs;

  // A stage may advance when out_ready is high or any stage at or beyond it
  // is empty; written as a running AND so the chain has no combinational loop.
  always_comb begin
    adv       = '0;
    tail_full = 1'b1;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      tail_full = tail_full & v[k];
      adv[k]    = out_ready | ~tail_full;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;

    if (k == 0) begin : g_head
      assign up_v = in_valid;
      assign up_d = in_data;
    end else begin : g_body
      assign up_v = v[k-1];
      assign up_d = d[k-1];
    end

    lib_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv[k]),
      .flush    (flush),
      .up_valid (up_v),
      .up_data  (up_d),
      .valid    (v[k]),
      .data     (d[k])
    );
  end

  assign in_ready  = adv[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  assign in_hs.valid  = in_valid;
  assign in_hs.ready  = in_ready;
  assign out_hs.valid = out_valid;
  assign out_hs.ready = out_ready;

  // Tracks popcount(v) incrementally; a simultaneous push and pop cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if ((&in_hs) && !(&out_hs)) begin
      occupancy <= occupancy + OW'(1);
    end else if ((&out_hs) && !(&in_hs)) begin
      occupancy <= occupancy - OW'(1);
    end
  end

endmodule
